// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook sequencer.
// Time is four BCD digits {min_tens, min_units, sec_tens, sec_units}.
package microwave_pkg;

    localparam int BCD_W  = 4;
    localparam int TIME_W = 16;
    localparam int DIGITS = TIME_W / BCD_W;

    localparam logic [TIME_W-1:0] TIME_ZERO = '0;
    localparam logic [TIME_W-1:0] TIME_ONE  = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Largest value a single keypad digit may carry.
    localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

    function automatic logic digit_is_bcd(input logic [BCD_W-1:0] d);
        return d <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Four-digit BCD mm:ss register: keypad shift-in, clear, and one-step
// countdown with a flag that says the next decrement lands on 0000.
module bcd_down_counter
    import microwave_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BCD_W-1:0]  digit_i,
    input  logic              dec_i,
    output logic [TIME_W-1:0] time_o,
    output logic              zero_next_o
);

    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] time_d;
    logic [TIME_W-1:0] dec_val;
    logic              borrow;

    // Ripple borrow through the digits; seconds tens wraps to 5, all others to 9,
    // so literal entries such as 0075 count down 75, 74, ... without normalising.
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        dec_val = time_q;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (time_q[i*BCD_W +: BCD_W] == '0) begin
                    dec_val[i*BCD_W +: BCD_W] = (i == 1) ? 4'd5 : 4'd9;
                    borrow = 1'b1;
                end else begin
                    dec_val[i*BCD_W +: BCD_W] = time_q[i*BCD_W +: BCD_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        time_d = time_q;
        if (clear_i) begin
            time_d = TIME_ZERO;
        end else if (dec_i) begin
            time_d = dec_val;
        end else if (shift_i) begin
            time_d = {time_q[TIME_W-BCD_W-1:0], digit_i};
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_q <= TIME_ZERO;
        end else begin
            time_q <= time_d;
        end
    end

    assign time_o      = time_q;
    assign zero_next_o = (time_q == TIME_ONE);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: time entry, start/stop/door/clear gating of the
// magnetron, per-second BCD countdown and end-of-cook beeper.
module cook_sequencer
    import microwave_pkg::*;
#(
    parameter int BEEP_SECS = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic              digit_valid,
    input  logic [BCD_W-1:0]  digit,
    input  logic              sec_tick,
    output logic [TIME_W-1:0] time_bcd,
    output logic              magnetron_on,
    output logic              beep,
    output logic [2:0]        state
);

    localparam logic [3:0] BEEP_LAST = 4'(BEEP_SECS - 1);

    state_t     state_q, state_d;
    logic [3:0] beep_cnt_q, beep_cnt_d;
    logic       start_cur_q, start_prev_q;

    logic       start_fire;
    logic       digit_ok;
    logic       hold_req;
    logic       cnt_clear;
    logic       cnt_shift;
    logic       cnt_dec;
    logic       zero_next;
    logic [TIME_W-1:0] time_val;

    // Start is synchronised first, then edge-detected against its previous value,
    // which adds one cycle of latency but makes holding the button harmless.
    assign start_fire = start_prev_q & ~start_cur_q;
    assign digit_ok   = digit_valid & digit_is_bcd(digit);
    assign hold_req   = ~stopn | ~door_closed;

    always_comb begin
        state_d    = state_q;
        beep_cnt_d = beep_cnt_q;
        cnt_clear  = 1'b0;
        cnt_shift  = 1'b0;
        cnt_dec    = 1'b0;

        if (!clearn) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (digit_ok) begin
                        cnt_shift = 1'b1;
                        state_d   = ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (start_fire && door_closed && (time_val != TIME_ZERO)) begin
                        state_d = ST_COOKING;
                    end else if (digit_ok) begin
                        cnt_shift = 1'b1;
                    end
                end
                ST_COOKING: begin
                    // A hold in the same cycle as a tick swallows that tick.
                    if (hold_req) begin
                        state_d = ST_PAUSED;
                    end else if (sec_tick) begin
                        cnt_dec = 1'b1;
                        if (zero_next) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!hold_req && start_fire) begin
                        state_d = ST_COOKING;
                    end
                end
                ST_DONE: begin
                    if (!door_closed) begin
                        state_d = ST_IDLE;
                    end else if (sec_tick) begin
                        if (beep_cnt_q == BEEP_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            beep_cnt_d = beep_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end

        if (state_d != ST_DONE) begin
            beep_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            beep_cnt_q   <= '0;
            start_cur_q  <= 1'b1;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            beep_cnt_q   <= beep_cnt_d;
            start_cur_q  <= startn;
            start_prev_q <= start_cur_q;
        end
    end

    bcd_down_counter u_counter (
        .clk         (clk),
        .rst_n       (resetn),
        .clear_i     (cnt_clear),
        .shift_i     (cnt_shift),
        .digit_i     (digit),
        .dec_i       (cnt_dec),
        .time_o      (time_val),
        .zero_next_o (zero_next)
    );

    assign time_bcd     = time_val;
    assign magnetron_on = (state_q == ST_COOKING);
    assign beep         = (state_q == ST_DONE);
    assign state        = state_q;

endmodule
